// File: rtl/hall_call_latch.sv
// Hall-call front end: debounces buttons, latches per-floor requests until acked, ages them.
// Optional HALL_LAMP_EN adds a hall_lamp output that blinks on overdue requests.
module hall_call_latch #(
  parameter int NUM_FLOORS      = 4,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int AGE_LIMIT       = 200,
  parameter int AGE_W           = 8
`ifdef HALL_LAMP_EN
  ,
  parameter int BLINK_HALF      = 16
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_FLOORS-1:0]               button_in,
  input  logic [NUM_FLOORS-1:0]               request_ack,
  input  logic                                emergency_stop,
  output logic [NUM_FLOORS-1:0]               floor_requests,
  output logic [NUM_FLOORS-1:0]               overdue,
  output logic [$clog2(NUM_FLOORS+1)-1:0]     pending_count,
  output logic                                new_request
`ifdef HALL_LAMP_EN
  ,
  output logic [NUM_FLOORS-1:0]               hall_lamp
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PC_W  = $clog2(NUM_FLOORS + 1);
  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [CNT_W-1:0]      cnt   [NUM_FLOORS];
  logic [CNT_W-1:0]      cnt_n [NUM_FLOORS];
  logic [AGE_W-1:0]      age   [NUM_FLOORS];
  logic [AGE_W-1:0]      age_n [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] armed, armed_n;
  logic [NUM_FLOORS-1:0] req_n, ovd_n;
  logic [PC_W-1:0]       pc_n;
  logic                  press;

  always_comb begin
    req_n   = floor_requests;
    armed_n = armed;
    ovd_n   = '0;
    pc_n    = '0;
    press   = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      cnt_n[i] = cnt[i];
      age_n[i] = age[i];
      if (emergency_stop) begin
        cnt_n[i]   = '0;
        age_n[i]   = '0;
        armed_n[i] = 1'b1;
        req_n[i]   = 1'b0;
      end else begin
        // The press fires on the edge the counter arrives at the limit; disarming keeps a held button to one event.
        if (button_in[i]) begin
          cnt_n[i] = (cnt[i] == DB_MAX) ? cnt[i] : cnt[i] + 1'b1;
          press    = armed[i] && (cnt_n[i] == DB_MAX);
          if (press) armed_n[i] = 1'b0;
        end else begin
          cnt_n[i]   = '0;
          armed_n[i] = 1'b1;
          press      = 1'b0;
        end
        if (request_ack[i]) begin
          req_n[i] = 1'b0;
          age_n[i] = '0;
        end else if (press && !floor_requests[i]) begin
          req_n[i] = 1'b1;
          age_n[i] = '0;
        end else if (floor_requests[i]) begin
          age_n[i] = (age[i] == AGE_MAX) ? age[i] : age[i] + 1'b1;
        end
      end
      ovd_n[i] = req_n[i] && (age_n[i] == AGE_MAX);
      pc_n     = pc_n + PC_W'(req_n[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
        cnt[i] <= '0;
        age[i] <= '0;
      end
      armed          <= '1;
      floor_requests <= '0;
      overdue        <= '0;
      pending_count  <= '0;
      new_request    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
        cnt[i] <= cnt_n[i];
        age[i] <= age_n[i];
      end
      armed          <= armed_n;
      floor_requests <= req_n;
      overdue        <= ovd_n;
      pending_count  <= pc_n;
      new_request    <= |(req_n & ~floor_requests);
    end
  end

`ifdef HALL_LAMP_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0]         blink_cnt;
  logic                  blink_tick;
  logic [NUM_FLOORS-1:0] lamp_n;

  assign blink_tick = (blink_cnt == BW'(BLINK_HALF - 1));

  // Each lamp starts high when its floor becomes overdue, then flips on the shared tick.
  always_comb begin
    lamp_n = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (ovd_n[i])
        lamp_n[i] = !overdue[i] ? 1'b1 : (blink_tick ? ~hall_lamp[i] : hall_lamp[i]);
      else
        lamp_n[i] = req_n[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      hall_lamp <= '0;
    end else begin
      blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
      hall_lamp <= lamp_n;
    end
  end
`endif

endmodule

// File: tb/tb_hall_call_latch.sv
// Directed vector bench for hall_call_latch (DEBOUNCE_CYCLES=3, AGE_LIMIT=20).
module tb_hall_call_latch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] button_in = '0;
  logic [3:0] request_ack = '0;
  logic       emergency_stop = 1'b0;
  logic [3:0] floor_requests;
  logic [3:0] overdue;
  logic [2:0] pending_count;
  logic       new_request;
`ifdef HALL_LAMP_EN
  logic [3:0] hall_lamp;
`endif

  int errors = 0;
  int checks = 0;

  hall_call_latch #(
    .NUM_FLOORS(4),
    .DEBOUNCE_CYCLES(3),
    .AGE_LIMIT(20),
    .AGE_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_in(button_in),
    .request_ack(request_ack),
    .emergency_stop(emergency_stop),
    .floor_requests(floor_requests),
    .overdue(overdue),
    .pending_count(pending_count),
    .new_request(new_request)
`ifdef HALL_LAMP_EN
    ,
    .hall_lamp(hall_lamp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       es;
    logic [3:0] btn;
    logic [3:0] ack;
    logic [3:0] req;
    logic [3:0] ovd;
    logic [2:0] pc;
    logic       nr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic es, input logic [3:0] btn, input logic [3:0] ack,
                     input logic [3:0] req, input logic [2:0] pc, input logic nr);
    vec_t v;
    v.r = r; v.es = es; v.btn = btn; v.ack = ack;
    v.req = req; v.ovd = 4'b0000; v.pc = pc; v.nr = nr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  // Drive inputs just after an edge, then advance past the next edge.
  task automatic step(input logic r, input logic es, input logic [3:0] btn, input logic [3:0] ack);
    rst = r; emergency_stop = es; button_in = btn; request_ack = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst es btn ack | req pc new
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b0100, 4'b0000, 4'b0100, 1, 1);
    add(0, 0, 4'b0100, 4'b0000, 4'b0100, 1, 0);
    add(0, 0, 4'b0000, 4'b0000, 4'b0100, 1, 0);
    add(0, 0, 4'b0000, 4'b0100, 4'b0000, 0, 0);
    add(0, 0, 4'b1010, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b1010, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b1010, 4'b0000, 4'b1010, 2, 1);
    add(0, 0, 4'b0000, 4'b0000, 4'b1010, 2, 0);
    add(0, 0, 4'b0000, 4'b0010, 4'b1000, 1, 0);
    add(0, 0, 4'b0010, 4'b0000, 4'b1000, 1, 0);
    add(0, 0, 4'b0010, 4'b0000, 4'b1000, 1, 0);
    add(0, 0, 4'b0010, 4'b0010, 4'b1000, 1, 0);
    add(0, 0, 4'b0010, 4'b0000, 4'b1000, 1, 0);
    add(0, 0, 4'b0000, 4'b0000, 4'b1000, 1, 0);
    add(0, 0, 4'b1111, 4'b0000, 4'b1000, 1, 0);
    add(0, 0, 4'b1111, 4'b0000, 4'b1000, 1, 0);
    add(0, 0, 4'b1111, 4'b0000, 4'b1111, 4, 1);
    add(0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b1111, 4'b0000, 4'b1111, 4, 1);
    add(0, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    add(0, 0, 4'b0110, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b0110, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b0110, 4'b0000, 4'b0110, 2, 1);
    add(0, 0, 4'b1000, 4'b0000, 4'b0110, 2, 0);
    add(0, 0, 4'b1000, 4'b0000, 4'b0110, 2, 0);
    add(1, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b1000, 4'b0000, 4'b1000, 1, 1);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].es, vecs[i].btn, vecs[i].ack);
      chk("req", i, 32'(floor_requests), 32'(vecs[i].req));
      chk("ovd", i, 32'(overdue),        32'(vecs[i].ovd));
      chk("pc",  i, 32'(pending_count),  32'(vecs[i].pc));
      chk("new", i, 32'(new_request),    32'(vecs[i].nr));
    end

    // Held button with ack mid-hold: no re-set until released and re-pressed.
    step(1, 0, 4'b0000, 4'b0000);
    for (int n = 1; n <= 20; n++) begin
      step(0, 0, 4'b0100, (n == 10) ? 4'b0100 : 4'b0000);
      if (n == 3) chk("hold_set", n, 32'(floor_requests), 32'h4);
      if (n >= 10) chk("hold_clr", n, 32'(floor_requests), 32'h0);
    end
    step(0, 0, 4'b0000, 4'b0000);
    chk("rel", 0, 32'(floor_requests), 32'h0);
    for (int n = 1; n <= 3; n++) step(0, 0, 4'b0100, 4'b0000);
    chk("repress_req", 0, 32'(floor_requests), 32'h4);
    chk("repress_new", 0, 32'(new_request), 32'h1);

    // Ageing: overdue rises exactly 20 edges after the set edge and holds.
    step(1, 0, 4'b0000, 4'b0000);
    for (int n = 1; n <= 3; n++) step(0, 0, 4'b0001, 4'b0000);
    chk("age_set", 0, 32'(floor_requests), 32'h1);
    chk("age_ovd0", 0, 32'(overdue), 32'h0);
    for (int k = 1; k <= 25; k++) begin
      step(0, 0, 4'b0000, 4'b0000);
      chk("age_ovd", k, 32'(overdue), (k >= 20) ? 32'h1 : 32'h0);
    end
    step(0, 0, 4'b0000, 4'b0001);
    chk("age_ack_req", 0, 32'(floor_requests), 32'h0);
    chk("age_ack_ovd", 0, 32'(overdue), 32'h0);
    chk("age_ack_pc", 0, 32'(pending_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
